// File: rtl/dispensador_pkg.sv
// Shared definitions for the beverage selector and dispenser: state codes,
// component codes and the phase-sequencing helper.
package dispensador_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BASE   = 3'd1;
  localparam logic [2:0] S_MEZCLA = 3'd2;
  localparam logic [2:0] S_SABOR  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [1:0] B_NONE  = 2'd0;
  localparam logic [1:0] B_CAFE  = 2'd1;
  localparam logic [1:0] B_TE    = 2'd2;
  localparam logic [1:0] M_NONE  = 2'd0;
  localparam logic [1:0] M_LECHE = 2'd1;
  localparam logic [1:0] M_AGUA  = 2'd2;

  // First enabled phase strictly after 'desde' (IDLE starts the search at BASE).
  function automatic logic [2:0] siguiente_fase(input logic [2:0] desde,
                                                input logic en_base,
                                                input logic en_mezcla,
                                                input logic en_sabor);
    logic [2:0] w_sig;
    w_sig = S_FIN;
    if (desde == S_IDLE && en_base)
      w_sig = S_BASE;
    else if ((desde == S_IDLE || desde == S_BASE) && en_mezcla)
      w_sig = S_MEZCLA;
    else if ((desde == S_IDLE || desde == S_BASE || desde == S_MEZCLA) && en_sabor)
      w_sig = S_SABOR;
    return w_sig;
  endfunction

endpackage

// File: rtl/dispensador_bebidas_temporizador.sv
// Phase timer: loads the phase duration on entry and counts seconds down;
// 'expira' flags the tick that consumes the last second.
module temporizador_fase
  import dispensador_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_valor,
  input  logic          i_tick,
  output logic          o_expira
);

  logic [TW-1:0] r_cuenta;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_cuenta <= '0;
    else if (i_load)
      r_cuenta <= i_valor;
    else if (i_tick && r_cuenta != '0)
      r_cuenta <= r_cuenta - 1'b1;
  end

  assign o_expira = i_tick && (r_cuenta == TW'(1));

endmodule

// File: rtl/dispensador_bebidas.sv
// Drink dispenser: accepts one order via valid/ready, then runs the base,
// mixer and flavour valve phases in sequence, each timed in seconds.
module dispensador_bebidas
  import dispensador_pkg::*;
#(
  parameter int T_BASE   = 5,
  parameter int T_MEZCLA = 3,
  parameter int T_SABOR  = 2,
  parameter int TW       = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick,
  input  logic       i_order_valid,
  input  logic [1:0] i_order_base,
  input  logic [1:0] i_order_mix,
  input  logic       i_order_vainilla,
  output logic       o_order_ready,
  output logic       o_valv_cafe,
  output logic       o_valv_te,
  output logic       o_valv_leche,
  output logic       o_valv_agua,
  output logic       o_valv_vainilla,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_estado
);

  logic [2:0]    r_estado;
  logic [2:0]    w_sig_estado;
  logic [1:0]    r_base;
  logic [1:0]    r_mix;
  logic          r_vainilla;
  logic          w_acepta;
  logic [1:0]    w_base_sel;
  logic [1:0]    w_mix_sel;
  logic          w_vainilla_sel;
  logic          w_en_base;
  logic          w_en_mezcla;
  logic          w_en_sabor;
  logic          w_expira;
  logic          w_carga;
  logic [TW-1:0] w_valor;

  // While idle, phase enables come from the order being accepted this edge.
  assign w_acepta       = (r_estado == S_IDLE) && i_order_valid;
  assign w_base_sel     = (r_estado == S_IDLE) ? i_order_base     : r_base;
  assign w_mix_sel      = (r_estado == S_IDLE) ? i_order_mix      : r_mix;
  assign w_vainilla_sel = (r_estado == S_IDLE) ? i_order_vainilla : r_vainilla;

  assign w_en_base   = (w_base_sel == B_CAFE || w_base_sel == B_TE) && (T_BASE >= 1);
  assign w_en_mezcla = (w_mix_sel == M_LECHE || w_mix_sel == M_AGUA) && (T_MEZCLA >= 1);
  assign w_en_sabor  = w_vainilla_sel && (T_SABOR >= 1);

  assign w_carga = (w_sig_estado != r_estado) &&
                   (w_sig_estado == S_BASE || w_sig_estado == S_MEZCLA || w_sig_estado == S_SABOR);

  always_comb begin
    w_valor = '0;
    case (w_sig_estado)
      S_BASE:   w_valor = TW'(T_BASE);
      S_MEZCLA: w_valor = TW'(T_MEZCLA);
      S_SABOR:  w_valor = TW'(T_SABOR);
      default:  w_valor = '0;
    endcase
  end

  temporizador_fase #(.TW(TW)) u_temporizador (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_carga),
    .i_valor   (w_valor),
    .i_tick    (i_tick),
    .o_expira  (w_expira)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_estado <= S_IDLE;
    else
      r_estado <= w_sig_estado;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_base     <= B_NONE;
      r_mix      <= M_NONE;
      r_vainilla <= 1'b0;
    end else if (w_acepta) begin
      r_base     <= i_order_base;
      r_mix      <= i_order_mix;
      r_vainilla <= i_order_vainilla;
    end
  end

  always_comb begin
    w_sig_estado = r_estado;
    case (r_estado)
      S_IDLE:
        if (i_order_valid)
          w_sig_estado = siguiente_fase(S_IDLE, w_en_base, w_en_mezcla, w_en_sabor);
      S_BASE, S_MEZCLA, S_SABOR:
        if (w_expira)
          w_sig_estado = siguiente_fase(r_estado, w_en_base, w_en_mezcla, w_en_sabor);
      S_FIN:   w_sig_estado = S_IDLE;
      default: w_sig_estado = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so at most one valve can be high.
  always_comb begin
    o_order_ready   = (r_estado == S_IDLE);
    o_busy          = (r_estado != S_IDLE);
    o_done          = (r_estado == S_FIN);
    o_estado        = r_estado;
    o_valv_cafe     = 1'b0;
    o_valv_te       = 1'b0;
    o_valv_leche    = 1'b0;
    o_valv_agua     = 1'b0;
    o_valv_vainilla = 1'b0;
    case (r_estado)
      S_BASE: begin
        o_valv_cafe = (r_base == B_CAFE);
        o_valv_te   = (r_base == B_TE);
      end
      S_MEZCLA: begin
        o_valv_leche = (r_mix == M_LECHE);
        o_valv_agua  = (r_mix == M_AGUA);
      end
      S_SABOR: o_valv_vainilla = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dispensador_bebidas.sv
// Self-checking bench for dispensador_bebidas: table of whole orders plus
// hand-written reset, empty-order and mid-order-reset sequences.
module tb_dispensador_bebidas;
  import dispensador_pkg::*;

  typedef struct {
    logic [1:0] base;
    logic [1:0] mix;
    logic       vain;
    int         eCafe;
    int         eTe;
    int         eLeche;
    int         eAgua;
    int         eVain;
    logic [4:0] eFirst;
    logic [7:0] eMask;
  } orderVec_t;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_tick;
  logic       i_order_valid;
  logic [1:0] i_order_base;
  logic [1:0] i_order_mix;
  logic       i_order_vainilla;
  logic       o_order_ready;
  logic       o_valv_cafe;
  logic       o_valv_te;
  logic       o_valv_leche;
  logic       o_valv_agua;
  logic       o_valv_vainilla;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_estado;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       tickEn;
  int         cntCafe, cntTe, cntLeche, cntAgua, cntVain, doneCnt, overlapCnt;
  logic [7:0] visited;
  orderVec_t  vecs[6];
  orderVec_t  junkVec;
  orderVec_t  waterVec;

  always #5 clk = ~clk;

  dispensador_bebidas dut (
    .i_clk            (clk),
    .i_reset_n        (i_reset_n),
    .i_tick           (i_tick),
    .i_order_valid    (i_order_valid),
    .i_order_base     (i_order_base),
    .i_order_mix      (i_order_mix),
    .i_order_vainilla (i_order_vainilla),
    .o_order_ready    (o_order_ready),
    .o_valv_cafe      (o_valv_cafe),
    .o_valv_te        (o_valv_te),
    .o_valv_leche     (o_valv_leche),
    .o_valv_agua      (o_valv_agua),
    .o_valv_vainilla  (o_valv_vainilla),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_estado         (o_estado)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [4:0] valves();
    return {o_valv_cafe, o_valv_te, o_valv_leche, o_valv_agua, o_valv_vainilla};
  endfunction

  // Ticks are counted while a valve is high, i.e. the ticks the phase will consume.
  task automatic monitor();
    if (o_valv_cafe     && i_tick) cntCafe++;
    if (o_valv_te       && i_tick) cntTe++;
    if (o_valv_leche    && i_tick) cntLeche++;
    if (o_valv_agua     && i_tick) cntAgua++;
    if (o_valv_vainilla && i_tick) cntVain++;
    if ($countones(valves()) > 1) overlapCnt++;
    if (o_done === 1'b1) doneCnt++;
    visited[o_estado] = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    i_tick = tickEn && (cyc % 4 == 0);
    @(negedge clk);
    monitor();
  endtask

  task automatic clearCounters();
    cntCafe = 0; cntTe = 0; cntLeche = 0; cntAgua = 0; cntVain = 0;
    doneCnt = 0; overlapCnt = 0; visited = '0;
  endtask

  task automatic applyStimulus(input orderVec_t v, input bit junk);
    bit finished;
    clearCounters();
    i_order_base     = v.base;
    i_order_mix      = v.mix;
    i_order_vainilla = v.vain;
    i_order_valid    = 1'b1;
    cycle();
    if (!junk) i_order_valid = 1'b0;
    checkOutput("accept_ready", o_order_ready, 0);
    checkOutput("accept_busy", o_busy, 1);
    checkOutput("first_valve", valves(), v.eFirst);
    finished = 0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (o_done === 1'b1) begin
        i_order_valid = 1'b0;
        finished = 1;
        cycle();
      end else begin
        if (junk) begin
          i_order_valid    = ~i_order_valid;
          i_order_base     = i_order_base + 2'd1;
          i_order_mix      = ~i_order_mix;
          i_order_vainilla = ~i_order_vainilla;
          checkOutput("junk_ready", o_order_ready, 0);
        end
        cycle();
      end
    end
    if (!finished) checkOutput("done_timeout", 0, 1);
    checkOutput("ticks_cafe", cntCafe, v.eCafe);
    checkOutput("ticks_te", cntTe, v.eTe);
    checkOutput("ticks_leche", cntLeche, v.eLeche);
    checkOutput("ticks_agua", cntAgua, v.eAgua);
    checkOutput("ticks_vainilla", cntVain, v.eVain);
    checkOutput("done_pulses", doneCnt, 1);
    checkOutput("valve_overlap", overlapCnt, 0);
    checkOutput("states_visited", visited, v.eMask);
    checkOutput("end_estado", o_estado, S_IDLE);
    checkOutput("end_ready", o_order_ready, 1);
  endtask

  initial begin
    vecs[0] = '{2'd1, 2'd1, 1'b1, 5, 0, 3, 0, 2, 5'b10000, 8'h1F};
    vecs[1] = '{2'd2, 2'd0, 1'b0, 0, 5, 0, 0, 0, 5'b01000, 8'h13};
    vecs[2] = '{2'd3, 2'd0, 1'b0, 0, 0, 0, 0, 0, 5'b00000, 8'h11};
    vecs[3] = '{2'd0, 2'd2, 1'b1, 0, 0, 0, 3, 2, 5'b00010, 8'h1D};
    vecs[4] = '{2'd3, 2'd3, 1'b1, 0, 0, 0, 0, 2, 5'b00001, 8'h19};
    vecs[5] = '{2'd1, 2'd2, 1'b0, 5, 0, 0, 3, 0, 5'b10000, 8'h17};
    junkVec  = '{2'd1, 2'd0, 1'b0, 5, 0, 0, 0, 0, 5'b10000, 8'h13};
    waterVec = '{2'd0, 2'd2, 1'b0, 0, 0, 0, 3, 0, 5'b00010, 8'h15};

    tickEn           = 1'b1;
    i_tick           = 1'b0;
    i_reset_n        = 1'b0;
    i_order_valid    = 1'b1;
    i_order_base     = 2'd1;
    i_order_mix      = 2'd1;
    i_order_vainilla = 1'b1;
    clearCounters();

    // Reset wins over a pending order for three consecutive edges.
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("rst_estado", o_estado, S_IDLE);
      checkOutput("rst_ready", o_order_ready, 1);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_done", o_done, 0);
      checkOutput("rst_valves", valves(), 0);
    end
    i_reset_n     = 1'b1;
    i_order_valid = 1'b0;
    cycle();
    checkOutput("rst_no_accept", o_busy, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0);

    // Empty order: FIN right after acceptance, idle one cycle later.
    i_order_base     = 2'd3;
    i_order_mix      = 2'd0;
    i_order_vainilla = 1'b0;
    i_order_valid    = 1'b1;
    cycle();
    i_order_valid = 1'b0;
    checkOutput("empty_fin", o_estado, S_FIN);
    checkOutput("empty_done", o_done, 1);
    checkOutput("empty_valves", valves(), 0);
    cycle();
    checkOutput("empty_idle", o_estado, S_IDLE);
    checkOutput("empty_ready", o_order_ready, 1);
    checkOutput("empty_done_off", o_done, 0);

    applyStimulus(junkVec, 1'b1);

    // Reset while the milk phase still has two seconds left.
    clearCounters();
    i_order_base     = 2'd0;
    i_order_mix      = 2'd1;
    i_order_vainilla = 1'b0;
    i_order_valid    = 1'b1;
    cycle();
    i_order_valid = 1'b0;
    for (int i = 0; i < 100 && cntLeche < 1; i++) cycle();
    checkOutput("mid_tick_seen", cntLeche, 1);
    cycle();
    checkOutput("mid_mezcla", o_estado, S_MEZCLA);
    checkOutput("mid_leche", o_valv_leche, 1);
    i_reset_n = 1'b0;
    cycle();
    checkOutput("mid_rst_estado", o_estado, S_IDLE);
    checkOutput("mid_rst_valves", valves(), 0);
    checkOutput("mid_rst_done", o_done, 0);
    checkOutput("mid_rst_busy", o_busy, 0);
    i_reset_n = 1'b1;
    cycle();
    checkOutput("mid_after_estado", o_estado, S_IDLE);
    checkOutput("mid_after_done", o_done, 0);

    applyStimulus(waterVec, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispensador_bebidas.md
# dispensador_bebidas

Executes a drink order produced by the beverage-selector FSM: it accepts one order through a valid/ready handshake, then opens the product valves in fixed phases (base, mixer, flavour), each timed in seconds by a one-cycle tick. It sits downstream of the selector and drives the valve outputs of the machine. The block completes one order at a time and returns to idle after a one-cycle completion pulse.

## Interface

- T_BASE, 5, duration of the coffee/tea phase in ticks
- T_MEZCLA, 3, duration of the milk/water phase in ticks
- T_SABOR, 2, duration of the vanilla phase in ticks
- TW, 4, width of the phase timer; each T_* must be ≤ 2^TW−1
- CLK  in  1  single clock; all logic is on the rising edge
- RESET  in  1  synchronous, active-low reset
- TICK  in  1  one-CLK pulse per second, from the prescaler
- ORDER_VALID  in  1  order present
- ORDER_BASE  in  2  0 none, 1 coffee, 2 tea, 3 treated as none
- ORDER_MIX  in  2  0 none, 1 milk, 2 water, 3 treated as none
- ORDER_VAINILLA  in  1  add vanilla
- ORDER_READY  out  1  high only in IDLE
- VALV_CAFE, VALV_TE, VALV_LECHE, VALV_AGUA, VALV_VAINILLA  out  1 each  valve enables
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse in FIN
- ESTADO  out  3  current state code

## Operation

- States and codes: IDLE=0, BASE=1, MEZCLA=2, SABOR=3, FIN=4. Codes 5–7 are unreachable and go to IDLE.
- IDLE: ORDER_READY=1. When ORDER_VALID=1, the order is accepted on that edge. The block latches BASE/MIX/VAINILLA into internal registers and moves to the first enabled phase in the order BASE→MEZCLA→SABOR. If no phase is enabled, it moves to FIN.
- A phase is enabled when its latched component is not none and its T_* is ≥1. If T_*=0, the phase is skipped.
- On phase entry, the timer loads T_*. Each TICK decrements the timer. When TICK=1 and the timer equals 1, the block moves to the next enabled phase or to FIN. Cycles without TICK do not change the timer.
- Valve outputs:
  - BASE: VALV_CAFE or VALV_TE, according to the latched code.
  - MEZCLA: VALV_LECHE or VALV_AGUA, according to the latched code.
  - SABOR: VALV_VAINILLA.
  - At most one valve is high in any cycle.
- FIN: DONE=1 for exactly one cycle, all valves are 0, and the next state is IDLE.
- Order inputs are ignored whenever ORDER_READY=0. Input changes during an order do not affect it.
- RESET=0 on a clock edge, in any state, gives the following register values after that edge:
  - ESTADO=IDLE, ORDER_READY=1.
  - All valves 0, DONE=0, BUSY=0.
  - Timer 0, latched order cleared.
- RESET takes priority over a simultaneous TICK or ORDER_VALID.

## Timing

- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Order accepted at edge k: ORDER_READY=0 and the first valve is high starting at cycle k+1.
- A phase of T ticks ends on the edge where the T-th TICK since entry is sampled. A TICK in the entry cycle itself does not count, because the timer loads on the entry edge.
- Phase-to-phase change happens on one edge with no gap: the old valve drops and the new valve rises in the same cycle.
- The last phase ends at edge m, giving FIN at m+1 and IDLE at m+2. The next order can be accepted at edge m+2.
- Empty order accepted at edge k: FIN/DONE at cycle k+1, ORDER_READY=1 again at cycle k+2.

## Structure

- Shared package `dispensador_pkg`:
  - state encoding localparams (S_IDLE…S_FIN)
  - component codes (B_NONE, B_CAFE, B_TE, M_NONE, M_LECHE, M_AGUA)
- The selector FSM and its bench use the same package.
- One sub-module, `temporizador_fase`:
  - TW-bit down-counter with load, tick-enable and `expira` (timer==1 && TICK) outputs
  - synchronous active-low clear
- The FSM and valve decode stay in the top module.

## Test plan

- Reset behaviour: hold RESET=0 for 3 cycles with ORDER_VALID=1 → ESTADO=0, ORDER_READY=1, all valves/DONE/BUSY=0, and no order accepted.
- Full order: coffee+milk+vanilla with a TICK every 4 cycles → VALV_CAFE high for 5 ticks, VALV_LECHE for 3, VALV_VAINILLA for 2, one DONE pulse, then ORDER_READY=1. Check that no two valves overlap.
- Partial order: tea only (MIX=0, VAINILLA=0) → BASE→FIN, VALV_TE for 5 ticks, MEZCLA and SABOR never entered.
- Empty order: BASE=3, MIX=0, VAINILLA=0 → ESTADO 0→4→0, DONE high exactly 1 cycle, no valve ever asserted.
- Ignored inputs: toggle ORDER_VALID/ORDER_BASE while BUSY → latched order unchanged and ORDER_READY remains 0.
- Reset mid-order: RESET=0 during MEZCLA with timer=2 → next cycle all valves 0 and ESTADO=0, no DONE. A new water-only order then runs 3 ticks normally.
